// File: rtl/writeback_buffer.sv
// writeback_buffer
//   Line-granular write-back buffer between the memory arbiter (upstream) and
//   the cacheline adaptor (downstream). Dirty-line evictions are absorbed into
//   a small FIFO and acknowledged in one cycle. Read misses are forwarded to
//   memory ahead of queued writebacks. Reads that hit a buffered line are
//   answered from the buffer. Buffered lines are drained whenever upstream is
//   idle.
//
// Parameters
//   DEPTH            number of 256-bit line entries (1..8)
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous active-low reset
//   arb_mem_*        upstream request/response (line address, bits [4:0] ignored)
//   arbiter_resp     one-cycle upstream completion pulse
//   wb_mem_*         downstream request/response (address bits [4:0] always 0)
module writeback_buffer #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  arb_mem_address,
  input  logic         arb_mem_read,
  input  logic         arb_mem_write,
  input  logic [255:0] arb_mem_wdata,
  output logic [255:0] arb_mem_rdata,
  output logic         arbiter_resp,
  output logic [31:0]  wb_mem_address,
  output logic         wb_mem_read,
  output logic         wb_mem_write,
  output logic [255:0] wb_mem_wdata,
  input  logic [255:0] wb_mem_rdata,
  input  logic         wb_mem_resp
);

  // A single-entry buffer still needs a one-bit pointer to keep the
  // declarations legal; it simply never leaves zero.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_ACK     = 3'd1,
    S_RD_HIT_ACK = 3'd2,
    S_RD_FWD     = 3'd3,
    S_DRAIN      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [26:0]        addr_q [DEPTH];
  logic [26:0]        addr_d [DEPTH];
  logic [255:0]       line_q [DEPTH];
  logic [255:0]       line_d [DEPTH];
  logic [255:0]       rdata_q, rdata_d;
  logic [26:0]        fwd_addr_q, fwd_addr_d;

  logic [DEPTH-1:0]   hit_vec_s;
  logic [PTR_W-1:0]   hit_idx_s;
  logic               hit_s;
  logic               full_s;
  logic               empty_s;

  // Offset bits of the upstream address carry no meaning at line granularity.
  logic               unused_s;
  assign unused_s = ^arb_mem_address[4:0];

  // Advance a FIFO pointer, wrapping modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_W'(DEPTH - 1)) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  // Address match against every valid entry. At most one entry can match, so
  // OR-ing the matching indices yields the hit index without a priority chain.
  always_comb begin
    hit_vec_s = '0;
    hit_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec_s[i] = valid_q[i] && (addr_q[i] == arb_mem_address[31:5]);
      hit_idx_s    = hit_idx_s | (hit_vec_s[i] ? PTR_W'(i) : PTR_W'(0));
    end
    hit_s   = |hit_vec_s;
    full_s  = (count_q == CNT_W'(DEPTH));
    empty_s = (count_q == CNT_W'(0));
  end

  // Next-state and buffer-update logic.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    line_d     = line_q;
    rdata_d    = rdata_q;
    fwd_addr_d = fwd_addr_q;

    case (state_q)
      S_IDLE: begin
        // A write wins over a simultaneous read.
        if (arb_mem_write) begin
          if (hit_s) begin
            // Coalesce into the existing entry; legal even when full.
            line_d[hit_idx_s] = arb_mem_wdata;
            state_d           = S_WR_ACK;
          end else if (!full_s) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = arb_mem_address[31:5];
            line_d[tail_q]  = arb_mem_wdata;
            tail_d          = next_ptr(tail_q);
            count_d         = count_q + CNT_W'(1);
            state_d         = S_WR_ACK;
          end else begin
            // Make room first; the held write is retried back in IDLE.
            state_d = S_DRAIN;
          end
        end else if (arb_mem_read) begin
          if (hit_s) begin
            rdata_d = line_q[hit_idx_s];
            state_d = S_RD_HIT_ACK;
          end else begin
            // A miss cannot conflict with buffered data, so it may overtake
            // the queued writebacks.
            fwd_addr_d = arb_mem_address[31:5];
            state_d    = S_RD_FWD;
          end
        end else if (!empty_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WR_ACK: begin
        state_d = S_IDLE;
      end

      S_RD_HIT_ACK: begin
        state_d = S_IDLE;
      end

      S_RD_FWD: begin
        if (wb_mem_resp) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RD_FWD;
        end
      end

      S_DRAIN: begin
        // A started drain always runs to completion.
        if (wb_mem_resp) begin
          valid_d[head_q] = 1'b0;
          head_d          = next_ptr(head_q);
          count_d         = count_q - CNT_W'(1);
          state_d         = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode. Everything is zero outside the states that own a bus, so
  // reset (which forces IDLE) drives all outputs low.
  always_comb begin
    arb_mem_rdata  = '0;
    arbiter_resp   = 1'b0;
    wb_mem_address = '0;
    wb_mem_read    = 1'b0;
    wb_mem_write   = 1'b0;
    wb_mem_wdata   = '0;

    case (state_q)
      S_WR_ACK: begin
        arbiter_resp = 1'b1;
      end

      S_RD_HIT_ACK: begin
        arbiter_resp  = 1'b1;
        arb_mem_rdata = rdata_q;
      end

      S_RD_FWD: begin
        // Address comes from a register so it stays stable until the response.
        wb_mem_read    = 1'b1;
        wb_mem_address = {fwd_addr_q, 5'b0};
        if (wb_mem_resp) begin
          arbiter_resp  = 1'b1;
          arb_mem_rdata = wb_mem_rdata;
        end else begin
          arbiter_resp  = 1'b0;
          arb_mem_rdata = '0;
        end
      end

      S_DRAIN: begin
        wb_mem_write   = 1'b1;
        wb_mem_address = {addr_q[head_q], 5'b0};
        wb_mem_wdata   = line_q[head_q];
      end

      default: begin
        arbiter_resp = 1'b0;
      end
    endcase
  end

  // State, FIFO bookkeeping and line storage; reset discards buffered lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      rdata_q    <= '0;
      fwd_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        line_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
      fwd_addr_q <= fwd_addr_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        line_q[i] <= line_d[i];
      end
    end
  end

endmodule

// File: doc/writeback_buffer.md
# writeback_buffer

Line-granular write-back buffer between the memory arbiter and the cacheline adaptor. Dirty-line evictions from the caches are absorbed into a small FIFO and acknowledged quickly. Read misses then reach memory ahead of queued writebacks. Buffered lines are drained to memory whenever the upstream port is idle, and reads that hit a buffered line are answered from the buffer.

## Interface
- DEPTH, 2, number of 256-bit line entries; legal range 1..8.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- arb_mem_address  in  32  upstream line address; bits [4:0] ignored.
- arb_mem_read  in  1  upstream read request; held until arbiter_resp.
- arb_mem_write  in  1  upstream write request; held until arbiter_resp.
- arb_mem_wdata  in  256  upstream write line.
- arb_mem_rdata  out  256  upstream read line; valid while arbiter_resp=1.
- arbiter_resp  out  1  one-cycle upstream completion pulse.
- wb_mem_address  out  32  downstream line address; bits [4:0] always 0.
- wb_mem_read  out  1  downstream read request.
- wb_mem_write  out  1  downstream write request.
- wb_mem_wdata  out  256  downstream write line.
- wb_mem_rdata  in  256  downstream read line; valid with wb_mem_resp.
- wb_mem_resp  in  1  downstream completion pulse.

## Operation
- Storage: DEPTH entries of {valid, addr[31:5], line[255:0]}, kept as a FIFO with head/tail pointers and an occupancy count of width $clog2(DEPTH)+1.
- Invariant: at most one valid entry per line address.
- Hit: a valid entry whose addr equals arb_mem_address[31:5].
- States: IDLE, WR_ACK, RD_HIT_ACK, RD_FWD, DRAIN.
- IDLE, evaluated in this priority order:
  - write that hits: overwrite that entry's line (coalesce, allowed even when full) -> WR_ACK.
  - write that misses and is not full: push at tail -> WR_ACK.
  - write that misses and is full -> DRAIN.
  - read that hits: register the entry's line -> RD_HIT_ACK.
  - read that misses -> RD_FWD.
  - no request and not empty -> DRAIN.
  - otherwise stay in IDLE.
- WR_ACK, RD_HIT_ACK: arbiter_resp=1 (RD_HIT_ACK drives the registered line on arb_mem_rdata) -> IDLE.
- RD_FWD:
  - wb_mem_read=1, wb_mem_address={arb_mem_address[31:5],5'b0}.
  - On wb_mem_resp: arbiter_resp=1 and arb_mem_rdata=wb_mem_rdata, combinationally in the same cycle -> IDLE.
  - A read miss never conflicts with buffered data, so forwarding it ahead of queued writes is safe.
- DRAIN:
  - wb_mem_write=1 with the head entry's address and line.
  - On wb_mem_resp: pop the head -> IDLE.
  - A started drain always completes; upstream requests wait during it.
- If arb_mem_read and arb_mem_write are asserted together, the write is serviced. This is an illegal input and the bench flags it.
- Downstream request, address and data stay stable from request assertion until wb_mem_resp.

## Timing
- Reset (rst=0, asynchronous):
  - State returns to IDLE, count=0, pointers=0, all valid bits cleared.
  - Buffered lines are discarded.
  - All outputs are 0 (rdata and wdata included).
  - This applies in every state, including mid-DRAIN and mid-RD_FWD. After reset the pending downstream transaction is abandoned and any late wb_mem_resp is ignored in IDLE.
- Buffered write or read hit: request seen in IDLE at cycle 0 -> arbiter_resp in cycle 1.
- Forwarded read: wb_mem_read asserted in cycle 1; arbiter_resp in the same cycle as wb_mem_resp.
- Upstream must deassert or change its request in the cycle after arbiter_resp. Otherwise a held request in IDLE is treated as a new one.
- Write to a full buffer with no hit: the head drains (DRAIN), then the write is retried in IDLE. arbiter_resp comes 2 cycles after the drain's wb_mem_resp.
- Drain begins the cycle after IDLE sees no request. Back-to-back upstream reads can postpone drains indefinitely.
- Pointer wrap-around is modulo DEPTH. For DEPTH=1, full equals non-empty.

## Test plan
- Reset with rst=0 at any time -> every output 0, buffer empty, no downstream request after release until a new upstream request.
- Write 0x1000_0044, line A, to empty buffer -> arbiter_resp in cycle 1 with no downstream traffic. Next idle cycle: wb_mem_write=1, wb_mem_address=0x1000_0040, wb_mem_wdata=A until wb_mem_resp, then empty.
- Write 0x40 A, then read 0x40 in cycle 2 -> arbiter_resp in cycle 3 with rdata A, wb_mem_read never asserted.
- Writes 0x80 B then 0x80 C back-to-back -> a single drain of 0x80 with C, count never exceeds 1.
- DEPTH=2: writes to 0x00, 0x20, then 0x40 -> 0x00 drained first; 0x40 acknowledged 2 cycles after that drain's wb_mem_resp. Then a read of 0x100 -> wb_mem_read to 0x100 before the remaining drains, with arbiter_resp coincident with wb_mem_resp and rdata passed through.
- Assert rst mid-DRAIN with wb_mem_write=1 -> wb_mem_write drops immediately. After release, a stray wb_mem_resp is ignored, the buffer is empty and no further write issues.
